// File: rtl/aes_mix_columns_iter.sv
// Iterative AES (Inverse)MixColumns over a full 128-bit state.
// NumColPar column datapaths are stepped across the four columns in
// 4/NumColPar cycles. The result is held on data_o until downstream accepts it.
module aes_mix_columns_iter #(
  parameter int NumColPar = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [3:0][3:0][7:0]  data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [3:0][3:0][7:0]  data_o,
  output logic                  op_err_o
);

  localparam int         NumIter  = 4 / NumColPar;
  localparam logic [1:0] CIPH_FWD = 2'b01;
  localparam logic [1:0] CIPH_INV = 2'b10;
  localparam logic [1:0] LastCnt  = 2'(NumIter - 1);

  if (!(NumColPar == 1 || NumColPar == 2 || NumColPar == 4)) begin : g_bad_param
    $error("aes_mix_columns_iter: NumColPar must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                        state_reg, state_next;
  logic [1:0]                    cnt_reg, cnt_next;
  logic [3:0][3:0][7:0]          data_reg, data_next;
  logic                          inv_reg, inv_next;
  logic                          err_reg, err_next;
  logic                          accept;
  logic [NumColPar-1:0][3:0][7:0] grp_out;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column: forward MixColumns, plus a correction term z for the inverse.
  function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] b, input logic inv);
    logic [7:0]       x0, x1, x2, x3, y0, y1, y2, z0, z1;
    logic [3:0][7:0]  o;
    x0 = b[0] ^ b[1];
    x1 = b[1] ^ b[2];
    x2 = b[2] ^ b[3];
    x3 = b[3] ^ b[0];
    o[0] = b[1] ^ xtime(x0) ^ x2;
    o[1] = b[0] ^ xtime(x1) ^ x2;
    o[2] = b[3] ^ xtime(x2) ^ x0;
    o[3] = b[2] ^ xtime(x3) ^ x0;
    y0 = xtime(xtime(b[0] ^ b[2]));
    y1 = xtime(xtime(b[1] ^ b[3]));
    y2 = xtime(y0 ^ y1);
    z0 = inv ? (y2 ^ y0) : 8'h00;
    z1 = inv ? (y2 ^ y1) : 8'h00;
    o[0] = o[0] ^ z0;
    o[2] = o[2] ^ z0;
    o[1] = o[1] ^ z1;
    o[3] = o[3] ^ z1;
    return o;
  endfunction

  // Per-lane column datapaths; lane gi works on column cnt*NumColPar + gi.
  for (genvar gi = 0; gi < NumColPar; gi++) begin : g_col
    logic [1:0]      col_idx;
    logic [3:0][7:0] col_in;
    assign col_idx = 2'(int'(cnt_reg) * NumColPar + gi);
    // Gather the selected column from the working state.
    always_comb begin
      col_in = '0;
      for (int r = 0; r < 4; r++) begin
        col_in[r] = data_reg[r][col_idx];
      end
    end
    assign grp_out[gi] = mix_col(col_in, inv_reg);
  end

  // Next-state, handshake outputs and in-place column update.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    inv_next    = inv_reg;
    err_next    = err_reg;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_o = 1'b1;
        accept     = in_valid_i;
      end
      BUSY: begin
        for (int c = 0; c < NumColPar; c++) begin
          for (int r = 0; r < 4; r++) begin
            data_next[r][2'(int'(cnt_reg) * NumColPar + c)] = grp_out[c][r];
          end
        end
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == LastCnt) begin
          cnt_next   = 2'd0;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) accept = 1'b1;
          else            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Accepting a new state overrides whatever the current state decided.
    if (accept) begin
      data_next  = data_i;
      inv_next   = (op_i == CIPH_INV);
      err_next   = (op_i != CIPH_FWD) && (op_i != CIPH_INV);
      cnt_next   = 2'd0;
      state_next = BUSY;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      data_reg  <= '0;
      inv_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      inv_reg   <= inv_next;
      err_reg   <= err_next;
    end
  end

  assign data_o   = data_reg;
  assign op_err_o = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench for aes_mix_columns_iter: one DUT per NumColPar value
// (1, 2, 4), each with its own driver and monitor, checked against a
// GF(2^8) matrix-multiply reference model.
module tb_aes_mix_columns_iter;

  typedef logic [3:0][3:0][7:0] st_t;
  typedef struct { st_t d; logic [1:0] op; st_t exp; logic err; } item_t;
  typedef struct { st_t exp; logic err; int acc; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int ncp, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s NumColPar=%0d: got %h expected %h", nm, ncp, act, req);
    end
  endtask

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: o_r = sum_k coef[(k-r) mod 4] * b_k.
  function automatic st_t ref_mix(input st_t s, input logic inv);
    logic [3:0][7:0] coef;
    st_t o;
    coef = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r][c] = 8'h00;
        for (int k = 0; k < 4; k++)
          o[r][c] = o[r][c] ^ gmul(coef[(k - r + 4) % 4], s[k][c]);
      end
    return o;
  endfunction

  // Build a state from four column words, row 0 in the most significant byte.
  function automatic st_t mkst(input logic [31:0] c0, input logic [31:0] c1,
                               input logic [31:0] c2, input logic [31:0] c3);
    logic [3:0][31:0] cols;
    st_t s;
    cols = {c3, c2, c1, c0};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = cols[c][31 - 8*r -: 8];
    return s;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    return s;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NCP = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int NIT = 4 / NCP;

    logic       rst, in_valid, in_ready, out_valid, out_ready, op_err;
    logic [1:0] op;
    st_t        din, dout;
    logic       fin = 1'b0;
    item_t      stim_q[$];
    exp_t       sb_q[$];

    aes_mix_columns_iter #(.NumColPar(NCP)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .data_i      (din),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .data_o      (dout),
      .op_err_o    (op_err)
    );

    // Monitor: compare every valid output cycle against the scoreboard head.
    initial begin
      logic seen = 1'b0;
      forever begin
        @(negedge clk);
        #2;
        if (!rst && out_valid) begin
          if (sb_q.size() == 0) begin
            check("spurious_out_valid", NCP, 128'(out_valid), 128'(0));
          end else begin
            if (!seen) begin
              check("latency", NCP, 128'(cycle - sb_q[0].acc), 128'(NIT));
              seen = 1'b1;
            end
            check("data_o", NCP, dout, sb_q[0].exp);
            check("op_err_o", NCP, 128'(op_err), 128'(sb_q[0].err));
            if (out_ready) begin
              $display("txn NumColPar=%0d data_o=%h op_err_o=%b", NCP, dout, op_err);
              void'(sb_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end

    // Driver: directed vectors, one long backpressure episode, random traffic, reset abort.
    initial begin
      item_t it;
      st_t   s;
      logic [1:0] rop;
      logic  accepted = 1'b0;
      int    acc_cnt = 0;
      int    bp_state = 0;
      int    bp_left = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; din = '0;

      it = '{mkst(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345), 2'b01,
             mkst(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc), 1'b0};
      stim_q.push_back(it);
      it = '{mkst(32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6), 2'b10,
             mkst(32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5), 1'b0};
      stim_q.push_back(it);
      it = '{mkst(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c), 2'b11,
             mkst(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8), 1'b1};
      stim_q.push_back(it);
      s = rand_st();
      it = '{s, 2'b01, ref_mix(s, 1'b0), 1'b0};
      stim_q.push_back(it);
      for (int k = 0; k < 2000; k++) begin
        s = rand_st();
        it = '{s, 2'b01, ref_mix(s, 1'b0), 1'b0};
        stim_q.push_back(it);
        it = '{ref_mix(s, 1'b0), 2'b10, s, 1'b0};
        stim_q.push_back(it);
        s = rand_st();
        rop = 2'($urandom());
        it = '{s, rop, ref_mix(s, rop == 2'b10), !(rop == 2'b01 || rop == 2'b10)};
        stim_q.push_back(it);
      end

      repeat (3) @(negedge clk);
      #1;
      check("reset_in_ready", NCP, 128'(in_ready), 128'(1));
      check("reset_out_valid", NCP, 128'(out_valid), 128'(0));
      check("reset_data_o", NCP, dout, 128'(0));
      check("reset_op_err", NCP, 128'(op_err), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      while (stim_q.size() > 0) begin
        @(negedge clk);
        if (accepted) begin
          in_valid = 1'b0;
          op = 2'($urandom());
          din = rand_st();
          accepted = 1'b0;
        end
        if (bp_state == 1 && out_valid) begin
          bp_state = 2;
          bp_left = 10;
        end
        if (bp_state == 2)      out_ready = 1'b0;
        else if (bp_state == 3) out_ready = 1'b1;
        else                    out_ready = ($urandom_range(3) != 0);
        if (!in_valid && ($urandom_range(3) != 0 || bp_state == 2 || bp_state == 3)) begin
          in_valid = 1'b1;
          din = stim_q[0].d;
          op = stim_q[0].op;
        end
        #1;
        if (bp_state == 2) begin
          check("in_ready_backpressure", NCP, 128'(in_ready), 128'(0));
          bp_left--;
          if (bp_left == 0) bp_state = 3;
        end else if (bp_state == 3) begin
          check("in_ready_release", NCP, 128'(in_ready), 128'(1));
          bp_state = 4;
        end
        if (in_valid && in_ready) begin
          sb_q.push_back('{stim_q[0].exp, stim_q[0].err, cycle + 1});
          void'(stim_q.pop_front());
          accepted = 1'b1;
          acc_cnt++;
          if (acc_cnt == 5 && bp_state == 0) bp_state = 1;
        end
      end

      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 50 && sb_q.size() > 0; t++) @(negedge clk);
      check("drain", NCP, 128'(sb_q.size()), 128'(0));

      // Reset while busy: no result may ever emerge for this input.
      @(negedge clk);
      in_valid = 1'b1;
      din = rand_st();
      op = 2'b01;
      #1;
      check("abort_accept", NCP, 128'(in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", NCP, 128'(out_valid), 128'(0));
      check("abort_in_ready", NCP, 128'(in_ready), 128'(1));
      check("abort_data_o", NCP, dout, 128'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #3;
      check("abort_no_output", NCP, 128'(out_valid), 128'(0));
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 95000 && !(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin); t++)
      @(posedge clk);
    check("all_done", 0, 128'({g_dut[2].fin, g_dut[1].fin, g_dut[0].fin}), 128'(3'b111));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
